control_sequencer: RTL and testbench

//  Hardwired control unit that sequences the single-bus CPU datapath: fetch, decode, execute.

---
 rtl/control_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the single-bus CPU datapath.
// All strobes are a Moore decode of the registered state and the IR held by the datapath.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int NREG = 16,
  parameter int RW   = 4
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            MDRout,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            IncPC,
  output logic            Read,
  output logic [OPW-1:0]  alu_op,
  output logic            busy,
  output logic            instr_done,
  output logic            illegal,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [OPW-1:0] op;
  logic [RW-1:0]  ra, rb, rc;
  logic           is_nop, is_halt, is_alu, is_muldiv;
  logic           unused_ir;

  assign op = ir[31 -: OPW];
  assign ra = ir[31-OPW -: RW];
  assign rb = ir[31-OPW-RW -: RW];
  assign rc = ir[31-OPW-2*RW -: RW];
  assign unused_ir = ^ir[31-OPW-3*RW:0];

  assign is_nop    = (op == OP_NOP);
  assign is_halt   = (op == OP_HALT);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                     (op == OP_OR) || is_muldiv;

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    ZHighout   = 1'b0;
    MDRout     = 1'b0;
    Rout       = '0;
    Rin        = '0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        ZLowIn  = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = mem_ready ? S_T2 : S_T1W;
      end
      // The incremented PC was already latched in T1; only the read is held.
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_nop) begin
          instr_done = 1'b1;
          state_d    = run ? S_T0 : S_IDLE;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_alu) begin
          Rout    = NREG'(1) << rb;
          Yin     = 1'b1;
          state_d = S_T4;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_T4: begin
        Rout    = NREG'(1) << rc;
        alu_op  = op;
        ZLowIn  = 1'b1;
        ZHighIn = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          Rin        = NREG'(1) << ra;
          instr_done = 1'b1;
          state_d    = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        ZHighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_T0 : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle strobe table for back-to-back ADD/MUL/NOP,
// plus hand-written memory-wait, latency, HALT, illegal and reset sequences.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, run, mem_ready;
  logic [31:0] ir;
  logic        PCout, Zlowout, ZHighout, MDRout;
  logic [15:0] Rout, Rin;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZLowIn, ZHighIn, IncPC, Read;
  logic [4:0]  alu_op;
  logic        busy, instr_done, illegal;
  logic [3:0]  state_o;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] ADD_IR  = 32'h1A920000;
  localparam logic [31:0] MUL_IR  = 32'h72000000;
  localparam logic [31:0] NOP_IR  = 32'h00000000;
  localparam logic [31:0] HALT_IR = 32'hD8000000;
  localparam logic [31:0] BAD_IR  = 32'hF8000000;

  localparam logic [17:0] PCOUT = 18'h20000, ZLOUT = 18'h10000, ZHOUT = 18'h08000,
                          MDROUT = 18'h04000, MARIN = 18'h02000, PCIN = 18'h01000,
                          MDRIN = 18'h00800, IRIN = 18'h00400, YIN = 18'h00200,
                          HIIN = 18'h00100, LOIN = 18'h00080, ZLIN = 18'h00040,
                          ZHIN = 18'h00020, INCPC = 18'h00010, READ = 18'h00008,
                          DONE = 18'h00004, BUSY = 18'h00002, ILL = 18'h00001;

  localparam logic [17:0] ST_T0 = PCOUT | MARIN | INCPC | ZLIN | BUSY;
  localparam logic [17:0] ST_T1 = ZLOUT | PCIN | READ | MDRIN | BUSY;
  localparam logic [17:0] ST_T2 = MDROUT | IRIN | BUSY;

  logic [17:0] strb;
  assign strb = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                 HIin, LOin, ZLowIn, ZHighIn, IncPC, Read, instr_done, busy, illegal};

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .Rout(Rout), .Rin(Rin), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .IncPC(IncPC), .Read(Read), .alu_op(alu_op), .busy(busy),
    .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [17:0] strb;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  alu;
  } vec_t;

  vec_t vecs[20];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs just after the falling edge; outputs are sampled 1ns later
  task automatic drive(input logic r, input logic mr, input logic [31:0] i);
    @(negedge Clock);
    run = r;
    mem_ready = mr;
    ir = i;
    #1;
  endtask

  task automatic do_reset(input string name);
    @(negedge Clock);
    Clear = 1'b0;
    run = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1;
    chk({name, "_strobes"}, {14'b0, strb}, 32'h0);
    chk({name, "_rout_rin"}, {Rout, Rin}, 32'h0);
    chk({name, "_alu_op"}, {27'b0, alu_op}, 32'h0);
    Clear = 1'b1;
  endtask

  // every cycle: one-hot-or-zero register strobes, at most one bus driver
  always @(negedge Clock) begin
    #2;
    chk("rout_onehot0", {31'b0, $onehot0(Rout)}, 32'h1);
    chk("rin_onehot0", {31'b0, $onehot0(Rin)}, 32'h1);
    chk("one_bus_driver",
        {31'b0, $onehot0({PCout, Zlowout, ZHighout, MDRout, |Rout})}, 32'h1);
  end

  task automatic latency_run(input string name, input logic [31:0] i, input int exp_lat);
    int n;
    n = 0;
    exp_q.push_back(32'(exp_lat));
    drive(1'b1, 1'b1, i);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b1, i);
      if (instr_done) begin
        n = k;
        break;
      end
    end
    if (n == 0) $display("FAIL %s_timeout: no instr_done in 20 cycles, state %0d", name, state_o);
    chk({name, "_latency"}, 32'(n), exp_q.pop_front());
    drive(1'b0, 1'b1, i);
    chk({name, "_back_idle"}, {14'b0, strb}, 32'h0);
  endtask

  initial begin
    int pc_cnt, rd_cnt, nrand;
    Clear = 1'b1;
    run = 1'b0;
    mem_ready = 1'b1;
    ir = NOP_IR;

    // table: ADD, MUL back-to-back, NOP ending with run low
    vecs[0]  = '{1'b1, 1'b1, ADD_IR, 18'h0,               16'h0,    16'h0,    5'h00};
    vecs[1]  = '{1'b1, 1'b1, ADD_IR, ST_T0,               16'h0,    16'h0,    5'h00};
    vecs[2]  = '{1'b1, 1'b1, ADD_IR, ST_T1,               16'h0,    16'h0,    5'h00};
    vecs[3]  = '{1'b1, 1'b1, ADD_IR, ST_T2,               16'h0,    16'h0,    5'h00};
    vecs[4]  = '{1'b1, 1'b1, ADD_IR, YIN | BUSY,          16'h0004, 16'h0,    5'h00};
    vecs[5]  = '{1'b1, 1'b1, ADD_IR, ZLIN | ZHIN | BUSY,  16'h0010, 16'h0,    5'h03};
    vecs[6]  = '{1'b1, 1'b1, ADD_IR, ZLOUT | DONE | BUSY, 16'h0,    16'h0020, 5'h00};
    vecs[7]  = '{1'b1, 1'b1, MUL_IR, ST_T0,               16'h0,    16'h0,    5'h00};
    vecs[8]  = '{1'b1, 1'b1, MUL_IR, ST_T1,               16'h0,    16'h0,    5'h00};
    vecs[9]  = '{1'b1, 1'b1, MUL_IR, ST_T2,               16'h0,    16'h0,    5'h00};
    vecs[10] = '{1'b1, 1'b1, MUL_IR, YIN | BUSY,          16'h0001, 16'h0,    5'h00};
    vecs[11] = '{1'b1, 1'b1, MUL_IR, ZLIN | ZHIN | BUSY,  16'h0001, 16'h0,    5'h0E};
    vecs[12] = '{1'b1, 1'b1, MUL_IR, ZLOUT | LOIN | BUSY, 16'h0,    16'h0,    5'h00};
    vecs[13] = '{1'b1, 1'b1, MUL_IR, ZHOUT | HIIN | DONE | BUSY, 16'h0, 16'h0, 5'h00};
    vecs[14] = '{1'b1, 1'b1, NOP_IR, ST_T0,               16'h0,    16'h0,    5'h00};
    vecs[15] = '{1'b0, 1'b1, NOP_IR, ST_T1,               16'h0,    16'h0,    5'h00};
    vecs[16] = '{1'b0, 1'b1, NOP_IR, ST_T2,               16'h0,    16'h0,    5'h00};
    vecs[17] = '{1'b0, 1'b1, NOP_IR, DONE | BUSY,         16'h0,    16'h0,    5'h00};
    vecs[18] = '{1'b0, 1'b1, NOP_IR, 18'h0,               16'h0,    16'h0,    5'h00};
    vecs[19] = '{1'b0, 1'b0, ADD_IR, 18'h0,               16'h0,    16'h0,    5'h00};

    do_reset("power_on_reset");

    for (int v = 0; v < 20; v++) begin
      drive(vecs[v].run, vecs[v].mr, vecs[v].ir);
      chk($sformatf("vec%0d_strobes", v), {14'b0, strb}, {14'b0, vecs[v].strb});
      chk($sformatf("vec%0d_rout", v), {16'b0, Rout}, {16'b0, vecs[v].rout});
      chk($sformatf("vec%0d_rin", v), {16'b0, Rin}, {16'b0, vecs[v].rin});
      chk($sformatf("vec%0d_alu_op", v), {27'b0, alu_op}, {27'b0, vecs[v].alu});
    end

    // memory wait: mem_ready low for the T1 cycle and two T1W cycles
    drive(1'b1, 1'b1, ADD_IR);
    drive(1'b0, 1'b1, ADD_IR);
    chk("wait_t0", {14'b0, strb}, {14'b0, ST_T0});
    pc_cnt = 0;
    rd_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, (k == 3), ADD_IR);
      pc_cnt += int'(PCin);
      rd_cnt += int'(Read & MDRin);
    end
    chk("wait_pcin_cycles", 32'(pc_cnt), 32'd1);
    chk("wait_read_cycles", 32'(rd_cnt), 32'd4);
    drive(1'b0, 1'b1, ADD_IR);
    chk("wait_then_t2", {14'b0, strb}, {14'b0, ST_T2});
    repeat (4) drive(1'b0, 1'b1, ADD_IR);
    chk("wait_finish_idle", {14'b0, strb}, 32'h0);

    // latency from IDLE with run dropping right after start
    latency_run("add", ADD_IR, 6);
    latency_run("mul", MUL_IR, 7);
    latency_run("nop", NOP_IR, 4);

    // HALT opcode: stops after T3 and holds regardless of run
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, HALT_IR);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, HALT_IR);
      chk("halt_hold", {14'b0, strb}, 32'h0);
    end
    do_reset("reset_from_halt");

    // illegal opcode: sticky flag, HALT, cleared only by Clear
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, BAD_IR);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, ADD_IR);
      chk("illegal_hold", {14'b0, strb}, {14'b0, ILL});
    end
    do_reset("reset_from_illegal");

    // reset from a random mid-instruction point
    nrand = $urandom_range(2, 6);
    drive(1'b1, 1'b1, ADD_IR);
    for (int k = 0; k < nrand; k++) drive(1'b1, 1'b1, ADD_IR);
    chk("mid_instr_busy", {31'b0, busy}, 32'h1);
    do_reset("reset_mid_instr");
    drive(1'b0, 1'b1, ADD_IR);
    chk("reset_stays_idle", {14'b0, strb}, 32'h0);

    @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
